wb_lsu_master: RTL and testbench
================================

Name: wb_lsu_master

Overview:
- Wishbone pipelined-mode master (initiator) that turns one load/store request per transaction from the pipeline MEM stage into one single-beat bus cycle.
- Generates the byte select and lane-replicated write data, waits out stall/ack, then returns sign/zero-extended load data.
- Sits between the pipeline's memory stage and the data-memory Wishbone responder. Holds the pipeline through `o_busy` until `o_done`.

Parameters:
- ADDR_W, 13, byte-address width driven on `o_wb_addr`; the responder uses bits [ADDR_W-1:2] as its word index.
- TIMEOUT_CYCLES, 16, cycles to wait for ack before aborting; only used when WB_TIMEOUT_EN is defined.

Ports:
- i_clk  input  1  clock; all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_req  input  1  request strobe from MEM stage; sampled only in IDLE
- i_we  input  1  1 = store, 0 = load
- i_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- i_addr  input  32  byte address; low ADDR_W bits used
- i_wdata  input  32  store data; low byte/half/word used
- o_busy  output  1  high whenever state != IDLE
- o_done  output  1  one-cycle completion pulse
- o_err  output  1  valid with o_done: misaligned, illegal funct3 or timeout
- o_rdata  output  32  extended load data; valid with o_done; 0 for stores and errors
- o_wb_cyc  output  1  bus cycle
- o_wb_stb  output  1  request strobe
- o_wb_we  output  1  write enable
- o_wb_addr  output  ADDR_W  byte address
- o_wb_data  output  32  write data
- o_wb_sel  output  4  byte lane select
- i_wb_ack  input  1  responder ack
- i_wb_stall  input  1  responder stall
- i_wb_data  input  32  responder read data

Behaviour:
- Reset: state IDLE; every output is 0.
- Reset mid-transaction drops cyc/stb at that edge. Any later ack is ignored. No o_done is produced.
- States:
  - IDLE
  - REQ: cyc=1, stb=1
  - WAIT: cyc=1, stb=0
  - DONE: o_done=1 for one cycle, then back to IDLE
- IDLE, i_req=1, request legal: register addr, we, sel and lane data, then go to REQ.
- IDLE, i_req=1, request illegal: go to DONE with o_err=1 and no bus cycle. Illegal means any of:
  - H/HU with addr[0]=1
  - W with addr[1:0]!=0
  - any other funct3
  - store with funct3 not in {000, 001, 010}
- i_req while o_busy is ignored.
- REQ: stb stays high and all bus outputs stay stable while i_wb_stall=1.
  - stall=0 and ack=0: go to WAIT.
  - stall=0 and ack=1 (same-cycle responder): capture data, go to DONE.
- WAIT: on ack, capture i_wb_data and go to DONE; cyc drops at that edge.
- Ack seen in IDLE, or in REQ while stall=1, is ignored.
- Lane generation:
  - B: sel = 0001 << addr[1:0]; data = {4{wdata[7:0]}}
  - H: sel = 0011 << {addr[1],0}; data = {2{wdata[15:0]}}
  - W: sel = 1111; data = wdata
  - Loads drive the same sel with we=0.
- Load extraction: lane = i_wb_data >> (8*addr[1:0]).
  - B / H: sign-extend from bit 7 / 15.
  - BU / HU: zero-extend.
- Latency with a zero-stall, registered-ack responder:
  - i_req at edge N
  - stb visible in cycle N+1
  - ack visible in cycle N+2
  - o_done in cycle N+3
- Each stall cycle adds one cycle.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments every cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES without ack drops cyc/stb and goes to DONE with o_err=1, o_rdata=0.
  - A late ack is ignored.
- Undefined: no counter; the master waits indefinitely.

Test Plan:
- Word 0x8899AABB at byte 0x010. LW 0x010 → o_rdata=0x8899AABB, err=0, o_done exactly 3 cycles after i_req.
- Same word. LB 0x011 → 0xFFFFFFAA. LBU 0x013 → 0x00000088. LH 0x012 → 0xFFFF8899. LHU 0x010 → 0x0000AABB.
- SB 0x012 with wdata=0x000000CC → sel=0100, data=0xCCCCCCCC. A following LW 0x010 → 0x88CCAABB.
- Responder holds stall=1 for 3 cycles on SW 0x020 wdata 0x12345678 → stb and bus outputs stable throughout, o_done 3 cycles later than baseline, readback correct.
- LW 0x012 and LH 0x013 → no cyc ever asserted, o_done with err=1 one cycle after req. i_req during busy → ignored, exactly one o_done.
- i_rst pulsed while in WAIT → cyc=stb=0 next cycle, no o_done. With WB_TIMEOUT_EN and a silent responder → o_done err=1 after 16 cycles.

Source files
------------

// File: rtl/wb_lsu_master_if.sv
// -----------------------------------------------------------------------------
// wb_lsu_master_if
// Wishbone pipelined-mode bus bundle between the load/store master and the
// data-memory responder.
//   master modport : drives o_wb_cyc/stb/we/addr/data/sel, receives
//                    i_wb_ack/stall/data
//   slave modport  : the mirror image, used by the responder side
// Parameter ADDR_W sets the byte-address width carried on o_wb_addr.
// -----------------------------------------------------------------------------
interface wb_lsu_master_if #(
  parameter int ADDR_W = 13
);
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [ADDR_W-1:0] o_wb_addr;
  logic [31:0]       o_wb_data;
  logic [3:0]        o_wb_sel;
  logic              i_wb_ack;
  logic              i_wb_stall;
  logic [31:0]       i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_ack, i_wb_stall, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_ack, i_wb_stall, i_wb_data
  );
endinterface

// File: rtl/wb_lsu_master.sv
// -----------------------------------------------------------------------------
// wb_lsu_master
// Turns one load/store request from the pipeline MEM stage into one
// single-beat Wishbone pipelined-mode bus cycle. Builds byte selects and
// lane-replicated store data, waits out stall/ack, and returns sign- or
// zero-extended load data with a one-cycle o_done pulse.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_req/i_we/i_funct3/i_addr/i_wdata   request from MEM stage (IDLE only)
//   o_busy             high whenever the FSM is not IDLE
//   o_done/o_err/o_rdata   completion pulse, error flag, extended load data
//   wb                 Wishbone master modport (wb_lsu_master_if)
//
// Optional feature: define WB_TIMEOUT_EN to abort a bus cycle that has not
// been acknowledged within TIMEOUT_CYCLES cycles (o_err=1, o_rdata=0).
// Without it the master waits for ack indefinitely.
// -----------------------------------------------------------------------------
module wb_lsu_master #(
  parameter int ADDR_W         = 13,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rdata,
  wb_lsu_master_if.master       wb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;

  logic        req_legal_s;
  logic [3:0]  req_sel_s;
  logic [31:0] req_data_s;

  // Upper address bits are outside the responder's window.
  logic unused_addr_s;
  assign unused_addr_s = ^i_addr[31:ADDR_W];

  // Legal: B/BU any alignment, H/HU half-aligned, W word-aligned;
  // BU/HU exist only as loads.
  function automatic logic req_legal_f(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
    case (f3)
      3'b000:  req_legal_f = 1'b1;
      3'b001:  req_legal_f = ~a[0];
      3'b010:  req_legal_f = (a == 2'b00);
      3'b100:  req_legal_f = ~we;
      3'b101:  req_legal_f = ~we & ~a[0];
      default: req_legal_f = 1'b0;
    endcase
  endfunction

  // f3[1:0] encodes the access size for both signed and unsigned forms.
  function automatic logic [3:0] lane_sel_f(input logic [2:0] f3,
                                            input logic [1:0] a);
    case (f3[1:0])
      2'b00:   lane_sel_f = 4'b0001 << a;
      2'b01:   lane_sel_f = 4'b0011 << {a[1], 1'b0};
      2'b10:   lane_sel_f = 4'b1111;
      default: lane_sel_f = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data_f(input logic [2:0] f3,
                                              input logic [31:0] d);
    case (f3[1:0])
      2'b00:   lane_data_f = {4{d[7:0]}};
      2'b01:   lane_data_f = {2{d[15:0]}};
      default: lane_data_f = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext_f(input logic [2:0] f3,
                                             input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] lane_s;
    lane_s = d >> {a, 3'b000};
    case (f3)
      3'b000:  load_ext_f = {{24{lane_s[7]}}, lane_s[7:0]};
      3'b001:  load_ext_f = {{16{lane_s[15]}}, lane_s[15:0]};
      3'b010:  load_ext_f = lane_s;
      3'b100:  load_ext_f = {24'd0, lane_s[7:0]};
      3'b101:  load_ext_f = {16'd0, lane_s[15:0]};
      default: load_ext_f = 32'd0;
    endcase
  endfunction

  // Decode the incoming request: legality, byte selects, replicated data.
  always_comb begin
    req_legal_s = req_legal_f(i_we, i_funct3, i_addr[1:0]);
    req_sel_s   = lane_sel_f(i_funct3, i_addr[1:0]);
    req_data_s  = lane_data_f(i_funct3, i_wdata);
  end

`ifdef WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             tmo_hit_s;

  // Abort on the edge that would complete TIMEOUT_CYCLES cycles of waiting.
  always_comb begin
    tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
  end
`else
  localparam int unused_tmo_c = TIMEOUT_CYCLES;
`endif

  // Transaction FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'd0;
      addr_lo_r    <= 2'd0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_rdata      <= 32'd0;
      wb.o_wb_cyc  <= 1'b0;
      wb.o_wb_stb  <= 1'b0;
      wb.o_wb_we   <= 1'b0;
      wb.o_wb_addr <= {ADDR_W{1'b0}};
      wb.o_wb_data <= 32'd0;
      wb.o_wb_sel  <= 4'd0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt_r    <= {TMO_W{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_done  <= 1'b0;
          o_err   <= 1'b0;
          o_rdata <= 32'd0;
          if (i_req) begin
            o_busy    <= 1'b1;
            we_r      <= i_we;
            funct3_r  <= i_funct3;
            addr_lo_r <= i_addr[1:0];
            if (req_legal_s) begin
              wb.o_wb_cyc  <= 1'b1;
              wb.o_wb_stb  <= 1'b1;
              wb.o_wb_we   <= i_we;
              wb.o_wb_addr <= i_addr[ADDR_W-1:0];
              wb.o_wb_data <= req_data_s;
              wb.o_wb_sel  <= req_sel_s;
`ifdef WB_TIMEOUT_EN
              tmo_cnt_r    <= {TMO_W{1'b0}};
`endif
              state_r      <= ST_REQ;
            end else begin
              // Illegal request completes immediately without touching the bus.
              o_done  <= 1'b1;
              o_err   <= 1'b1;
              state_r <= ST_DONE;
            end
          end else begin
            o_busy <= 1'b0;
          end
        end

        ST_REQ: begin
`ifdef WB_TIMEOUT_EN
          tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
`endif
          // An ack while stalled belongs to nobody and is ignored.
          if (!wb.i_wb_stall && wb.i_wb_ack) begin
            wb.o_wb_cyc <= 1'b0;
            wb.o_wb_stb <= 1'b0;
            o_done      <= 1'b1;
            o_err       <= 1'b0;
            o_rdata     <= we_r ? 32'd0 : load_ext_f(funct3_r, addr_lo_r, wb.i_wb_data);
            state_r     <= ST_DONE;
          end
`ifdef WB_TIMEOUT_EN
          else if (tmo_hit_s) begin
            wb.o_wb_cyc <= 1'b0;
            wb.o_wb_stb <= 1'b0;
            o_done      <= 1'b1;
            o_err       <= 1'b1;
            o_rdata     <= 32'd0;
            state_r     <= ST_DONE;
          end
`endif
          else if (!wb.i_wb_stall) begin
            wb.o_wb_stb <= 1'b0;
            state_r     <= ST_WAIT;
          end else begin
            // Stalled: hold stb and every bus output.
            state_r <= ST_REQ;
          end
        end

        ST_WAIT: begin
`ifdef WB_TIMEOUT_EN
          tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
`endif
          if (wb.i_wb_ack) begin
            wb.o_wb_cyc <= 1'b0;
            o_done      <= 1'b1;
            o_err       <= 1'b0;
            o_rdata     <= we_r ? 32'd0 : load_ext_f(funct3_r, addr_lo_r, wb.i_wb_data);
            state_r     <= ST_DONE;
          end
`ifdef WB_TIMEOUT_EN
          else if (tmo_hit_s) begin
            wb.o_wb_cyc <= 1'b0;
            o_done      <= 1'b1;
            o_err       <= 1'b1;
            o_rdata     <= 32'd0;
            state_r     <= ST_DONE;
          end
`endif
          else begin
            state_r <= ST_WAIT;
          end
        end

        ST_DONE: begin
          o_done  <= 1'b0;
          o_err   <= 1'b0;
          o_rdata <= 32'd0;
          o_busy  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          wb.o_wb_cyc <= 1'b0;
          wb.o_wb_stb <= 1'b0;
          o_done      <= 1'b0;
          o_err       <= 1'b0;
          o_busy      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// -----------------------------------------------------------------------------
// tb_wb_lsu_master
// Directed bench for wb_lsu_master. A small registered-ack Wishbone responder
// with a programmable stall count backs a 64-word memory. Expected results
// are pushed to a scoreboard queue when a request is driven and popped when
// o_done appears. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_lsu_master;

  localparam int ADDR_W = 13;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_rdata;

  wb_lsu_master_if #(.ADDR_W(ADDR_W)) wbif ();

  wb_lsu_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (i_req),
    .i_we     (i_we),
    .i_funct3 (i_funct3),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err),
    .o_rdata  (o_rdata),
    .wb       (wbif)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- responder ----------------
  logic [31:0] mem [64];
  int          stall_budget = 0;   // written by the stimulus only
  int          stall_done   = 0;   // written by the responder only
  bit          silent       = 1'b0;

  assign wbif.i_wb_stall = wbif.o_wb_cyc && wbif.o_wb_stb && !silent &&
                           (stall_done < stall_budget);

  always @(posedge i_clk) begin
    if (wbif.o_wb_cyc && wbif.o_wb_stb && !silent) begin
      if (wbif.i_wb_stall) begin
        stall_done     <= stall_done + 1;
        wbif.i_wb_ack  <= 1'b0;
      end else begin
        stall_done     <= 0;
        wbif.i_wb_ack  <= 1'b1;
        wbif.i_wb_data <= mem[wbif.o_wb_addr[7:2]];
        if (wbif.o_wb_we) begin
          for (int b = 0; b < 4; b++) begin
            if (wbif.o_wb_sel[b]) mem[wbif.o_wb_addr[7:2]][8*b +: 8] <= wbif.o_wb_data[8*b +: 8];
          end
        end
      end
    end else begin
      wbif.i_wb_ack <= 1'b0;
    end
  end

  // ---------------- monitors ----------------
  int done_cnt = 0;
  int cyc_cnt  = 0;
  logic [31:0] last_rdata = 32'd0;

  always @(negedge i_clk) begin
    if (o_done) begin
      done_cnt   = done_cnt + 1;
      last_rdata = o_rdata;
    end
    if (wbif.o_wb_cyc) cyc_cnt = cyc_cnt + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request at the current falling edge and follow it to o_done.
  // n_stable = number of cycles after the request in which stb and the bus
  // outputs must hold; 0 means the request must never reach the bus.
  task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] exp_sel, input logic [31:0] exp_bus,
                        input int n_stable, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    exp_t e;
    exp_t got;
    int   cyc0;
    int   lat_obs;
    bit   seen;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
    exp_q.push_back(e);
    cyc0 = cyc_cnt;
    seen = 1'b0;
    lat_obs = 0;
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    @(negedge i_clk);
    i_req = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k <= n_stable) begin
        chk({tag, "_stb"}, {31'd0, wbif.o_wb_stb}, 32'd1);
        chk({tag, "_sel"}, {28'd0, wbif.o_wb_sel}, {28'd0, exp_sel});
        chk({tag, "_addr"}, {19'd0, wbif.o_wb_addr}, {19'd0, addr[12:0]});
        chk({tag, "_we"}, {31'd0, wbif.o_wb_we}, {31'd0, we});
        if (we) chk({tag, "_wdat"}, wbif.o_wb_data, exp_bus);
      end
      if (o_done) begin
        seen = 1'b1;
        lat_obs = k;
        break;
      end
      @(negedge i_clk);
    end
    got = exp_q.pop_front();
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({tag, "_rdata"}, o_rdata, got.rdata);
      chk({tag, "_err"}, {31'd0, o_err}, {31'd0, got.err});
      chk({tag, "_lat"}, lat_obs, got.lat);
    end
    if (n_stable == 0) chk({tag, "_no_cyc"}, cyc_cnt - cyc0, 32'd0);
    @(negedge i_clk);
  endtask

  initial begin
    int d0;
    exp_t e;
    exp_t got;

    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done_err", {30'd0, o_done, o_err}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_bus", {wbif.o_wb_cyc, wbif.o_wb_stb, wbif.o_wb_we, wbif.o_wb_sel}, 7'd0);

    // Fill memory, then the basic load flavours (baseline latency 3).
    do_txn("sw10",  1'b1, 3'b010, 32'h010, 32'h8899AABB, 4'b1111, 32'h8899AABB, 1, 32'h0, 1'b0, 3);
    do_txn("lw10",  1'b0, 3'b010, 32'h010, 32'h0, 4'b1111, 32'h0, 1, 32'h8899AABB, 1'b0, 3);
    do_txn("lb11",  1'b0, 3'b000, 32'h011, 32'h0, 4'b0010, 32'h0, 1, 32'hFFFFFFAA, 1'b0, 3);
    do_txn("lbu13", 1'b0, 3'b100, 32'h013, 32'h0, 4'b1000, 32'h0, 1, 32'h00000088, 1'b0, 3);
    do_txn("lh12",  1'b0, 3'b001, 32'h012, 32'h0, 4'b1100, 32'h0, 1, 32'hFFFF8899, 1'b0, 3);
    do_txn("lhu10", 1'b0, 3'b101, 32'h010, 32'h0, 4'b0011, 32'h0, 1, 32'h0000AABB, 1'b0, 3);

    // Byte store replicates data across lanes and only byte 2 changes.
    do_txn("sb12",  1'b1, 3'b000, 32'h012, 32'h000000CC, 4'b0100, 32'hCCCCCCCC, 1, 32'h0, 1'b0, 3);
    do_txn("lw10b", 1'b0, 3'b010, 32'h010, 32'h0, 4'b1111, 32'h0, 1, 32'h88CCAABB, 1'b0, 3);

    // Three stall cycles: bus held for cycles 1..4, done three cycles late.
    stall_budget = 3;
    do_txn("sw20st", 1'b1, 3'b010, 32'h020, 32'h12345678, 4'b1111, 32'h12345678, 4, 32'h0, 1'b0, 6);
    stall_budget = 0;
    do_txn("lw20",  1'b0, 3'b010, 32'h020, 32'h0, 4'b1111, 32'h0, 1, 32'h12345678, 1'b0, 3);

    // Illegal requests: error one cycle after the request, bus untouched.
    do_txn("lw12x", 1'b0, 3'b010, 32'h012, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b1, 1);
    do_txn("lh13x", 1'b0, 3'b001, 32'h013, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b1, 1);
    do_txn("sbux",  1'b1, 3'b100, 32'h010, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b1, 1);
    do_txn("f011x", 1'b0, 3'b011, 32'h010, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b1, 1);

    // Request held while busy must not start a second transaction.
    d0 = done_cnt;
    e.rdata = 32'h88CCAABB; e.err = 1'b0; e.lat = 0;
    exp_q.push_back(e);
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h010;
    @(negedge i_clk);
    chk("busy_hi", {31'd0, o_busy}, 32'd1);
    i_funct3 = 3'b100; i_addr = 32'h013;
    @(negedge i_clk);
    i_req = 1'b0;
    repeat (8) @(negedge i_clk);
    got = exp_q.pop_front();
    chk("busy_one_done", done_cnt - d0, 32'd1);
    chk("busy_rdata", last_rdata, got.rdata);

    // Reset while in WAIT with a silent responder: bus drops, no completion.
    silent = 1'b1;
    d0 = done_cnt;
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h010;
    @(negedge i_clk);
    i_req = 1'b0;
    @(negedge i_clk);
    chk("wait_cyc", {30'd0, wbif.o_wb_cyc, wbif.o_wb_stb}, 32'd2);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_wait_bus", {30'd0, wbif.o_wb_cyc, wbif.o_wb_stb}, 32'd0);
    chk("rst_wait_busy", {31'd0, o_busy}, 32'd0);
    repeat (6) @(negedge i_clk);
    chk("rst_wait_no_done", done_cnt - d0, 32'd0);

`ifdef WB_TIMEOUT_EN
    // cyc is high for 16 cycles, the abort edge puts o_done in cycle 17.
    do_txn("tmo", 1'b0, 3'b010, 32'h010, 32'h0, 4'b1111, 32'h0, 1, 32'h0, 1'b1, 17);
    chk("tmo_bus", {31'd0, wbif.o_wb_cyc}, 32'd0);
`endif
    silent = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
